pulse_burst_generator: RTL and testbench
========================================

Name: pulse_burst_generator

Overview:
Transmit end of the board's event stream: on a start request it emits a burst of count_in clean, evenly spaced pulses on pulse_out. That line is the kind of synchronized event the event counter consumes. The block reports progress (busy, done, remaining) and drives HEX0 with the low nibble of the remaining-pulse count. All outputs are registered; the block has a single clock domain, CLOCK_50.

Parameters:
CW, 10, width of count_in / remaining
PERIOD, 4, clocks per pulse period (HIGH phase + LOW phase); legal range 2..255
HIGH_CYCLES, 2, clocks pulse_out is held high per pulse; legal range 1..PERIOD-1

Ports:
CLOCK_50  input  1  system clock; all state changes on its rising edge
reset  input  1  reset, asynchronous, active-high; clock CLOCK_50
start  input  1  one-cycle synchronous request; sampled only in IDLE
abort  input  1  synchronous; terminates a burst
count_in  input  CW  number of pulses to emit; captured with start
pulse_out  output  1  pulse stream
busy  output  1  high while a burst is in progress (HIGH/LOW states)
done  output  1  one-cycle strobe when a burst completes normally
remaining  output  CW  pulses not yet completed
HEX0  output  7  active-low 7-seg image of remaining[3:0]

Behaviour:
- Reset (asynchronous, any state): state=IDLE, pulse_out=0, busy=0, done=0, remaining=0, phase counter=0, HEX0=7'b1000000.
- States: IDLE, HIGH, LOW, DONE. Outputs are decoded into registers, so each output reflects the state entered on that edge.
- IDLE:
  - start=1, count_in=N>0, abort=0 -> HIGH. remaining=N, phase counter=0.
  - start=1, count_in=0 -> DONE. No pulse is emitted.
  - abort=1 takes priority over start and keeps the block in IDLE.
- HIGH: pulse_out=1, busy=1. After HIGH_CYCLES clocks -> LOW, and remaining decrements by 1 on that same edge.
- LOW: pulse_out=0, busy=1. After PERIOD-HIGH_CYCLES clocks:
  - remaining!=0 -> HIGH.
  - remaining==0 -> DONE.
- DONE: done=1, busy=0, pulse_out=0 for exactly one cycle, then -> IDLE.
- Latency:
  - start sampled at edge T -> pulse_out and busy high from cycle T+1.
  - Burst of N pulses: busy high for N*PERIOD cycles; done at cycle T+N*PERIOD+1.
- start outside IDLE (HIGH, LOW, DONE): ignored. count_in is not re-captured and the burst is unaffected.
- abort in HIGH, LOW or DONE: next cycle state=IDLE, pulse_out=0, busy=0, remaining=0, done=0.
- remaining never wraps: it decrements only in HIGH->LOW transitions and N>=1 is guaranteed on entry.
- count_in is treated as unsigned. Maximum burst is 2^CW-1 pulses.
- Phase counter: width ceil(log2(PERIOD)). It is cleared on every state change and never wraps within a phase.
- HEX0 segment codes, active-low, keyed by remaining[3:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - HEX0 is registered and updates one cycle after remaining.

Test Plan:
1. Defaults, count_in=3, start at cycle 0:
   - pulse_out high in cycles 1-2, 5-6 and 9-10.
   - remaining=3 at cycle 1; 2 at cycle 3; 1 at cycle 7; 0 at cycle 11.
   - busy high in cycles 1-12; done high only in cycle 13.
2. count_in=0, start at cycle 0 -> done=1 in cycle 1. pulse_out and busy never assert.
3. count_in=2, start; then start with count_in=9 at cycle 4 -> exactly 2 pulses are emitted and done occurs at cycle 9.
4. count_in=5, abort at cycle 6 (HIGH phase of the 2nd pulse) -> in cycle 7: pulse_out=0, busy=0, remaining=0. No done strobe follows.
5. count_in=4, assert reset asynchronously mid-LOW -> all outputs go to reset values immediately. After release, a new start with count_in=1 produces one pulse and done at cycle 5.
6. count_in=1023 -> HEX0=0001110 ("F") after start. Exactly 1023 rising edges on pulse_out; remaining ends at 0; HEX0=1000000; done after 4092 busy cycles.

Source files
------------

// File: rtl/pulse_burst_generator.sv
// Burst pulse generator: on start, emits count_in evenly spaced pulses on pulse_out.
// Reports busy/done/remaining and shows remaining[3:0] on a 7-segment digit.
module pulse_burst_generator #(
   parameter int unsigned CW          = 10,
   parameter int unsigned PERIOD      = 4,
   parameter int unsigned HIGH_CYCLES = 2
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] count_in,
   output logic          pulse_out,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] remaining,
   output logic [6:0]    HEX0
);

   localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0] HighLast = PW'(HIGH_CYCLES - 1);
   localparam logic [PW-1:0] LowLast  = PW'(PERIOD - HIGH_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic          pulse_q, busy_q, done_q;
   logic [6:0]    hex_q, hex_d;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      phase_d     = phase_q + PW'(1);
      unique case (state_q)
         StIdle: begin
            if (!abort && start) begin
               if (count_in == '0) begin
                  state_d = StDone;
               end else begin
                  state_d     = StHigh;
                  remaining_d = count_in;
               end
            end
         end
         StHigh: begin
            if (abort) begin
               state_d     = StIdle;
               remaining_d = '0;
            end else if (phase_q == HighLast) begin
               state_d     = StLow;
               remaining_d = remaining_q - CW'(1);
            end
         end
         StLow: begin
            if (abort) begin
               state_d     = StIdle;
               remaining_d = '0;
            end else if (phase_q == LowLast) begin
               state_d = (remaining_q != '0) ? StHigh : StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
            if (abort) remaining_d = '0;
         end
         default: state_d = StIdle;
      endcase
      // Phase counts clocks spent in the current state; idle holds it at zero.
      if (state_d != state_q || state_q == StIdle) phase_d = '0;
   end

   always_comb begin
      hex_d = 7'b1000000;
      case (remaining_q[3:0])
         4'h0: hex_d = 7'b1000000;
         4'h1: hex_d = 7'b1111001;
         4'h2: hex_d = 7'b0100100;
         4'h3: hex_d = 7'b0110000;
         4'h4: hex_d = 7'b0011001;
         4'h5: hex_d = 7'b0010010;
         4'h6: hex_d = 7'b0000010;
         4'h7: hex_d = 7'b1111000;
         4'h8: hex_d = 7'b0000000;
         4'h9: hex_d = 7'b0010000;
         4'hA: hex_d = 7'b0001000;
         4'hB: hex_d = 7'b0000011;
         4'hC: hex_d = 7'b1000110;
         4'hD: hex_d = 7'b0100001;
         4'hE: hex_d = 7'b0000110;
         4'hF: hex_d = 7'b0001110;
         default: hex_d = 7'b1000000;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state entered.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         phase_q     <= '0;
         remaining_q <= '0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         hex_q       <= 7'b1000000;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         remaining_q <= remaining_d;
         pulse_q     <= (state_d == StHigh);
         busy_q      <= (state_d == StHigh) || (state_d == StLow);
         done_q      <= (state_d == StDone);
         hex_q       <= hex_d;
      end
   end

   assign pulse_out = pulse_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = remaining_q;
   assign HEX0      = hex_q;

endmodule

// File: tb/tb_pulse_burst_generator.sv
// Bench for pulse_burst_generator: directed scenarios plus random traffic, checked
// every cycle against a timing-formula model of a burst.
module tb_pulse_burst_generator;

   localparam int P = 4;
   localparam int H = 2;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [9:0] count_in;
   logic       pulse_out;
   logic       busy;
   logic       done;
   logic [9:0] remaining;
   logic [6:0] HEX0;

   pulse_burst_generator dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .count_in  (count_in),
      .pulse_out (pulse_out),
      .busy      (busy),
      .done      (done),
      .remaining (remaining),
      .HEX0      (HEX0)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   logic [6:0] seg_ref [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int         n_checks = 0;
   int         n_bad    = 0;
   int         cyc      = 0;
   bit         m_act    = 0;
   int         m_t      = 0;
   int         m_n      = 0;
   logic [9:0] m_prev_rem = '0;
   int         rises    = 0;
   logic       prev_p   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // A burst accepted in cycle T with N pulses: offset k=1..N*P is busy, pulse i occupies
   // offsets i*P+1..i*P+H, and a pulse counts as completed from the cycle after its high phase.
   function automatic void expect_now(output logic e_p, output logic e_b, output logic e_d,
                                      output logic [9:0] e_r);
      int k;
      int fin;
      e_p = 1'b0;
      e_b = 1'b0;
      e_d = 1'b0;
      e_r = '0;
      if (m_act) begin
         k = cyc - m_t;
         if (k >= 1 && k <= m_n * P) begin
            e_b = 1'b1;
            e_p = ((k - 1) % P) < H;
            fin = (k - 1 + P - H) / P;
            if (fin > m_n) fin = m_n;
            e_r = 10'(m_n - fin);
         end else if (k == m_n * P + 1) begin
            e_d = 1'b1;
         end
      end
   endfunction

   task automatic tick(input bit st, input bit ab, input int cnt);
      logic       ep, eb, ed;
      logic [9:0] er;
      int         k;
      start    = st;
      abort    = ab;
      count_in = 10'(cnt);
      @(negedge CLOCK_50);
      expect_now(ep, eb, ed, er);
      check_eq("pulse_out", {31'd0, pulse_out}, {31'd0, ep});
      check_eq("busy", {31'd0, busy}, {31'd0, eb});
      check_eq("done", {31'd0, done}, {31'd0, ed});
      check_eq("remaining", {22'd0, remaining}, {22'd0, er});
      check_eq("HEX0", {25'd0, HEX0}, {25'd0, seg_ref[m_prev_rem[3:0]]});
      if (pulse_out && !prev_p) rises++;
      prev_p = pulse_out;
      @(posedge CLOCK_50);
      k = cyc - m_t;
      if (!m_act) begin
         if (!ab && st) begin
            m_act = 1;
            m_t   = cyc;
            m_n   = cnt;
         end
      end else if (ab || k >= m_n * P + 1) begin
         m_act = 0;
      end
      m_prev_rem = er;
      cyc++;
      #1;
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0);
   endtask

   task automatic async_reset();
      start = 0;
      abort = 0;
      #2 reset = 1'b1;
      #1;
      check_eq("rst_pulse", {31'd0, pulse_out}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_remaining", {22'd0, remaining}, 32'd0);
      check_eq("rst_HEX0", {25'd0, HEX0}, 32'h40);
      @(posedge CLOCK_50);
      cyc++;
      #1 reset = 1'b0;
      m_act      = 0;
      m_prev_rem = '0;
      prev_p     = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      count_in = '0;
      @(posedge CLOCK_50);
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
      idle_ticks(2);

      // Three pulses with defaults.
      tick(1, 0, 3);
      idle_ticks(15);
      // Zero-length burst: done only.
      tick(1, 0, 0);
      idle_ticks(3);
      // Restart request mid-burst is ignored.
      tick(1, 0, 2);
      idle_ticks(3);
      tick(1, 0, 9);
      idle_ticks(8);
      // Abort during the second pulse's high phase.
      tick(1, 0, 5);
      idle_ticks(5);
      tick(0, 1, 0);
      idle_ticks(6);
      // Asynchronous reset while in the low phase, then a single pulse.
      tick(1, 0, 4);
      idle_ticks(2);
      async_reset();
      idle_ticks(1);
      tick(1, 0, 1);
      idle_ticks(7);
      // Maximum-length burst.
      rises = 0;
      tick(1, 0, 1023);
      idle_ticks(1023 * P + 3);
      check_eq("max_rises", 32'(rises), 32'd1023);

      for (int i = 0; i < 3000; i++) begin
         int c;
         c = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 6);
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, c);
      end
      idle_ticks(10);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
